// File: rtl/trace_frame_rx_if.sv
// Byte stream from uart_rx into the trace deframer.
interface trace_frame_rx_if;
  logic       rx_dv;
  logic [7:0] rx_byte;

  modport master (output rx_dv, output rx_byte);
  modport slave  (input  rx_dv, input  rx_byte);
endinterface

// File: rtl/trace_frame_rx.sv
// Trace-link deframer: rebuilds pt/key/ct header and the sensor sample stream,
// tracks the first end-of-encryption marker and aborts frames on inter-byte gaps.
module trace_frame_rx #(
  parameter int BLOCK_SIZE         = 64,
  parameter int KEY_SIZE           = 80,
  parameter int SAMPLES_TO_COLLECT = 1024,
  parameter int DONE_MARK          = 253,
  parameter int IDLE_TIMEOUT       = 100000
) (
  input  logic                                  clk,
  input  logic                                  c10_resetn,
  trace_frame_rx_if.slave                       rx,
  output logic [BLOCK_SIZE-1:0]                 pt_o,
  output logic [KEY_SIZE-1:0]                   key_o,
  output logic [BLOCK_SIZE-1:0]                 ct_o,
  output logic                                  hdr_vld,
  output logic                                  smp_vld,
  output logic [7:0]                            smp_data,
  output logic [$clog2(SAMPLES_TO_COLLECT)-1:0] smp_idx,
  output logic                                  done_seen,
  output logic [$clog2(SAMPLES_TO_COLLECT)-1:0] done_idx,
  output logic                                  frame_done,
  output logic                                  frame_err,
  output logic                                  busy,
  output logic [15:0]                           frame_cnt
);

  localparam int IDX_W     = $clog2(SAMPLES_TO_COLLECT);
  localparam int PT_BYTES  = BLOCK_SIZE / 8;
  localparam int KEY_BYTES = KEY_SIZE / 8;
  localparam int MAX_BYTES = (KEY_BYTES > PT_BYTES) ? KEY_BYTES : PT_BYTES;
  localparam int BC_W      = $clog2(MAX_BYTES) + 1;

  localparam logic [BC_W-1:0]  PT_LAST  = BC_W'(PT_BYTES - 1);
  localparam logic [BC_W-1:0]  KEY_LAST = BC_W'(KEY_BYTES - 1);
  localparam logic [IDX_W-1:0] SMP_LAST = IDX_W'(SAMPLES_TO_COLLECT - 1);
  localparam logic [31:0]      GAP_MAX  = 32'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]       MARK     = 8'(DONE_MARK);

  typedef enum logic [2:0] {S_IDLE, S_PT, S_KEY, S_CT, S_SMP} state_t;

  state_t                state_q, state_d;
  logic [BC_W-1:0]       bcnt_q, bcnt_d;
  logic [31:0]           gap_q, gap_d;
  logic [IDX_W-1:0]      sidx_q, sidx_d;
  logic [BLOCK_SIZE-1:0] pt_sh_q, pt_sh_d;
  logic [KEY_SIZE-1:0]   key_sh_q, key_sh_d;
  // CT shadow omits the final byte: it is merged straight into ct_o.
  logic [BLOCK_SIZE-9:0] ct_sh_q, ct_sh_d;
  logic [BLOCK_SIZE-1:0] pt_q, pt_d, ct_q, ct_d;
  logic [KEY_SIZE-1:0]   key_q, key_d;
  logic                  hdr_vld_q, hdr_vld_d;
  logic                  smp_vld_q, smp_vld_d;
  logic [7:0]            smp_data_q, smp_data_d;
  logic [IDX_W-1:0]      smp_idx_q, smp_idx_d;
  logic                  done_seen_q, done_seen_d;
  logic [IDX_W-1:0]      done_idx_q, done_idx_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  expire;

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    gap_d        = gap_q;
    sidx_d       = sidx_q;
    pt_sh_d      = pt_sh_q;
    key_sh_d     = key_sh_q;
    ct_sh_d      = ct_sh_q;
    pt_d         = pt_q;
    key_d        = key_q;
    ct_d         = ct_q;
    hdr_vld_d    = 1'b0;
    smp_vld_d    = 1'b0;
    smp_data_d   = smp_data_q;
    smp_idx_d    = smp_idx_q;
    done_seen_d  = done_seen_q;
    done_idx_d   = done_idx_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    // A byte in the expiry cycle wins over the timeout.
    expire = (state_q != S_IDLE) && !rx.rx_dv && (gap_q + 32'd1 == GAP_MAX);
    if (state_q != S_IDLE)
      gap_d = rx.rx_dv ? '0 : gap_q + 32'd1;

    case (state_q)
      S_IDLE: if (rx.rx_dv) begin
        pt_sh_d     = {pt_sh_q[BLOCK_SIZE-9:0], rx.rx_byte};
        bcnt_d      = BC_W'(1);
        gap_d       = '0;
        done_seen_d = 1'b0;
        done_idx_d  = '0;
        state_d     = S_PT;
      end
      S_PT: if (rx.rx_dv) begin
        pt_sh_d = {pt_sh_q[BLOCK_SIZE-9:0], rx.rx_byte};
        if (bcnt_q == PT_LAST) begin
          bcnt_d  = '0;
          state_d = S_KEY;
        end else begin
          bcnt_d = bcnt_q + BC_W'(1);
        end
      end
      S_KEY: if (rx.rx_dv) begin
        key_sh_d = {key_sh_q[KEY_SIZE-9:0], rx.rx_byte};
        if (bcnt_q == KEY_LAST) begin
          bcnt_d  = '0;
          state_d = S_CT;
        end else begin
          bcnt_d = bcnt_q + BC_W'(1);
        end
      end
      S_CT: if (rx.rx_dv) begin
        if (bcnt_q == PT_LAST) begin
          pt_d      = pt_sh_q;
          key_d     = key_sh_q;
          ct_d      = {ct_sh_q, rx.rx_byte};
          hdr_vld_d = 1'b1;
          bcnt_d    = '0;
          sidx_d    = '0;
          state_d   = S_SMP;
        end else begin
          ct_sh_d = {ct_sh_q[BLOCK_SIZE-17:0], rx.rx_byte};
          bcnt_d  = bcnt_q + BC_W'(1);
        end
      end
      S_SMP: if (rx.rx_dv) begin
        smp_vld_d  = 1'b1;
        smp_data_d = rx.rx_byte;
        smp_idx_d  = sidx_q;
        if (rx.rx_byte == MARK && !done_seen_q) begin
          done_seen_d = 1'b1;
          done_idx_d  = sidx_q;
        end
        if (sidx_q == SMP_LAST) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          sidx_d       = '0;
          state_d      = S_IDLE;
        end else begin
          sidx_d = sidx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops the partial frame; published fields and counters stay put.
    if (expire) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
      bcnt_d      = '0;
      gap_d       = '0;
      sidx_d      = '0;
      pt_sh_d     = '0;
      key_sh_d    = '0;
      ct_sh_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!c10_resetn) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      gap_q        <= '0;
      sidx_q       <= '0;
      pt_sh_q      <= '0;
      key_sh_q     <= '0;
      ct_sh_q      <= '0;
      pt_q         <= '0;
      key_q        <= '0;
      ct_q         <= '0;
      hdr_vld_q    <= 1'b0;
      smp_vld_q    <= 1'b0;
      smp_data_q   <= '0;
      smp_idx_q    <= '0;
      done_seen_q  <= 1'b0;
      done_idx_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      gap_q        <= gap_d;
      sidx_q       <= sidx_d;
      pt_sh_q      <= pt_sh_d;
      key_sh_q     <= key_sh_d;
      ct_sh_q      <= ct_sh_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      ct_q         <= ct_d;
      hdr_vld_q    <= hdr_vld_d;
      smp_vld_q    <= smp_vld_d;
      smp_data_q   <= smp_data_d;
      smp_idx_q    <= smp_idx_d;
      done_seen_q  <= done_seen_d;
      done_idx_q   <= done_idx_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign pt_o       = pt_q;
  assign key_o      = key_q;
  assign ct_o       = ct_q;
  assign hdr_vld    = hdr_vld_q;
  assign smp_vld    = smp_vld_q;
  assign smp_data   = smp_data_q;
  assign smp_idx    = smp_idx_q;
  assign done_seen  = done_seen_q;
  assign done_idx   = done_idx_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/trace_frame_rx.md
# trace_frame_rx

Receive-side deframer for the trace link: consumes the byte stream from `uart_rx` and rebuilds the frame the capture FSM transmits. The frame is plaintext, key, ciphertext, then `SAMPLES_TO_COLLECT` sensor samples. Outputs are the three header fields, a per-sample stream with its index, and the position of the first end-of-encryption marker. It sits behind `uart_rx` on the loopback/second-board capture path and feeds trace storage or a checker.

## Interface
Parameters:
- `BLOCK_SIZE`, 64: plaintext/ciphertext width in bits; must be a multiple of 8.
- `KEY_SIZE`, 80: key width in bits; must be a multiple of 8.
- `SAMPLES_TO_COLLECT`, 1024: sensor samples per frame.
- `DONE_MARK`, 253: sample value that flags encryption done.
- `IDLE_TIMEOUT`, 100000: inter-byte gap, in clocks, that aborts a frame.

Ports:
- `clk`  in  1  single clock, the UART clock domain. All logic is on its rising edge.
- `c10_resetn`  in  1  reset, synchronous and active-low.
- `rx_dv`  in  1  one-cycle strobe; `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `pt_o`  out  BLOCK_SIZE  last complete plaintext.
- `key_o`  out  KEY_SIZE  last complete key.
- `ct_o`  out  BLOCK_SIZE  last complete ciphertext.
- `hdr_vld`  out  1  one-cycle pulse; `pt_o`/`key_o`/`ct_o` were updated.
- `smp_vld`  out  1  one-cycle pulse per sample.
- `smp_data`  out  8  sample value.
- `smp_idx`  out  clog2(SAMPLES_TO_COLLECT)  index of the sample, 0-based.
- `done_seen`  out  1  a `DONE_MARK` sample occurred in the current/last frame.
- `done_idx`  out  clog2(SAMPLES_TO_COLLECT)  index of the first `DONE_MARK` sample.
- `frame_done`  out  1  one-cycle pulse; all samples received.
- `frame_err`  out  1  one-cycle pulse; frame aborted by timeout.
- `busy`  out  1  FSM not in IDLE.
- `frame_cnt`  out  16  completed frames since reset; wraps from 0xFFFF to 0.

## Operation
- States: IDLE, PT, KEY, CT, SMP.
  - A byte counter tracks position within the current field.
  - The timeout counter is 32 bits.
- **IDLE.** An `rx_dv` is taken as PT byte 0. Same cycle: go to PT, clear `done_seen`/`done_idx`.
- **PT.** Collect BLOCK_SIZE/8 bytes, MSB first (first byte lands in bits [BLOCK_SIZE-1:BLOCK_SIZE-8]), into a shadow register. Then go to KEY.
- **KEY.** Collect KEY_SIZE/8 bytes, MSB first, into a shadow register. Then go to CT.
- **CT.** Collect BLOCK_SIZE/8 bytes, MSB first, into a shadow register.
  - On the last CT byte, copy all three shadows to `pt_o`/`key_o`/`ct_o` and pulse `hdr_vld`.
  - Go to SMP with the sample index at 0.
- **SMP.** Each `rx_dv` produces `smp_vld`, `smp_data`=byte, `smp_idx`=index, then the index increments.
  - If byte==`DONE_MARK` and `done_seen`==0: set `done_seen`, latch `done_idx`. Later marks are ignored.
  - On index SAMPLES_TO_COLLECT-1: pulse `frame_done`, increment `frame_cnt`, go to IDLE.
- **Timeout.** In any state other than IDLE, the gap counter increments every cycle without `rx_dv` and clears on `rx_dv`.
  - When it reaches IDLE_TIMEOUT-1: pulse `frame_err`, go to IDLE, discard shadows.
  - `pt_o`/`key_o`/`ct_o`, `frame_cnt` and `done_*` are unchanged.
- **Timeout and byte together.** If `rx_dv` arrives in the cycle the counter would expire, the byte wins: it is accepted and the counter clears.
- **Reset.** Active in any state, including mid-frame: the frame is discarded and the FSM returns to IDLE.

## Timing
- All outputs are registered.
- **Reset values:**
  - all outputs 0;
  - FSM IDLE;
  - counters 0.
- **`hdr_vld` latency.** Asserts the cycle after the `rx_dv` of the last CT byte; the new field values are visible in that same cycle.
- **Sample latency.** `smp_vld`/`smp_data`/`smp_idx` appear 1 cycle after the accepted `rx_dv`.
- **`done_idx`.** Valid from the cycle `smp_vld` carries the mark.
- **`frame_done`.** Asserts together with the last `smp_vld`. `frame_cnt` updates in the same cycle.
- **Back-to-back frames.** An `rx_dv` in the cycle after the last sample is accepted as PT byte 0 of the next frame.
- **`frame_err`.** Asserts exactly IDLE_TIMEOUT cycles after the last accepted byte.
- **Input rate.** `rx_dv` at most one per cycle; full rate is supported with no back-pressure.
- **Frame length.** (2·BLOCK_SIZE + KEY_SIZE)/8 + SAMPLES_TO_COLLECT bytes; 1050 with the defaults.

## Test plan
1. **Nominal frame.** Send PT=0x0123456789ABCDEF, key=0x00010203040506070809, CT=0xFEDCBA9876543210, samples i&0xFF, with sample 300 forced to 253.
   -> one `hdr_vld` with the exact field values; 1024 `smp_vld` with correct indices; `done_seen`=1, `done_idx`=300; one `frame_done`; `frame_cnt`=1.
2. **No marker.** Frame with all samples 0x10.
   -> `done_seen`=0 and `done_idx`=0 at `frame_done`.
3. **Two markers.** 253 at samples 10 and 500.
   -> `done_idx`=10.
4. **Timeout.** With IDLE_TIMEOUT=50, send 15 bytes, then idle.
   -> `frame_err` exactly 50 cycles after byte 15; no `hdr_vld`; header outputs keep prior values. A following full frame parses correctly.
   - Also send a byte exactly at cycle 49 of the gap -> it is accepted and no error occurs.
5. **Reset mid-frame.** Assert `c10_resetn`=0 for 1 cycle at sample 512.
   -> all outputs 0, `busy`=0. Next full frame -> `frame_cnt`=1.
6. **Back-to-back at full rate.** Two frames with `rx_dv` every cycle, no gap.
   -> two `hdr_vld`, 2048 `smp_vld`, `frame_cnt`=2, no `frame_err`.
